// File: rtl/video_pattern_sequencer_pkg.sv
// Shared types and constants for the video pattern sequencer: video
// coordinate widths, the test-pattern encoding, controller states and the
// 8-entry foreground palette used in AUTO mode.
package video_pattern_sequencer_pkg;

    localparam int VIDEO_X_BITWIDTH = 12;
    localparam int VIDEO_Y_BITWIDTH = 11;
    localparam int PALETTE_SIZE     = 8;

    typedef enum logic [2:0] {
        PAT_RAINBOW_AUTO = 3'd0,
        PAT_SOLID        = 3'd1,
        PAT_BARS         = 3'd2,
        PAT_CHECKER      = 3'd3,
        PAT_BORDER       = 3'd4
    } pattern_t;

    typedef enum logic {
        ST_AUTO   = 1'b0,
        ST_MANUAL = 1'b1
    } state_t;

    localparam logic [23:0] PALETTE [0:PALETTE_SIZE-1] = '{
        24'hff0000,
        24'h00ff00,
        24'hffff00,
        24'h0000ff,
        24'hff00ff,
        24'h00ffff,
        24'hffffff,
        24'hff9900
    };

    // Palette lookup; the 3-bit index covers exactly the 8 entries.
    function automatic logic [23:0] palette_color(input logic [2:0] idx);
        return PALETTE[idx];
    endfunction

endpackage

// File: rtl/video_pattern_sequencer_frame_tick_gen.sv
// Frame boundary detector: registers the last-active-pixel match, turns its
// rising edge into a single-cycle frame_start pulse and counts frames.
// Holding the last pixel for several cycles (blanking) yields one pulse only.
module frame_tick_gen
    import video_pattern_sequencer_pkg::*;
#(
    parameter int FRAME_CNT_BITS = 16
) (
    input  logic                        I_clk_pixel,
    input  logic                        I_reset_n,
    input  logic [VIDEO_X_BITWIDTH-1:0] pixX,
    input  logic [VIDEO_Y_BITWIDTH-1:0] pixY,
    input  logic [VIDEO_X_BITWIDTH-1:0] screenWidth,
    input  logic [VIDEO_Y_BITWIDTH-1:0] screenHeight,
    output logic                        O_frame_start,
    output logic [FRAME_CNT_BITS-1:0]   O_frame_cnt
);

    logic                      eof_d;
    logic                      eof_q;
    logic                      frame_start_d;
    logic                      frame_start_q;
    logic [FRAME_CNT_BITS-1:0] frame_cnt_d;
    logic [FRAME_CNT_BITS-1:0] frame_cnt_q;

    // Last-pixel compare, rising-edge detect against the registered match,
    // and a wrapping frame counter that advances together with the pulse.
    always_comb begin
        eof_d         = (pixX == (screenWidth - VIDEO_X_BITWIDTH'(1))) &&
                        (pixY == (screenHeight - VIDEO_Y_BITWIDTH'(1)));
        frame_start_d = eof_d && !eof_q;
        frame_cnt_d   = frame_cnt_q;
        if (frame_start_d) begin
            frame_cnt_d = frame_cnt_q + FRAME_CNT_BITS'(1);
        end
    end

    // Boundary state registers with synchronous active-low reset.
    always_ff @(posedge I_clk_pixel) begin
        if (!I_reset_n) begin
            eof_q         <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            eof_q         <= eof_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign O_frame_start = frame_start_q;
    assign O_frame_cnt   = frame_cnt_q;

endmodule

// File: rtl/video_pattern_sequencer.sv
// Frame-synchronous pattern/colour controller for the pixel generator.
// AUTO mode walks the palette every FRAMES_PER_STEP frames; a valid/ready
// request forces a pattern/colour that is only applied at the next frame
// boundary so the picture never tears. Requests offered while a previous one
// is still pending are dropped, not queued.
module video_pattern_sequencer
    import video_pattern_sequencer_pkg::*;
#(
    parameter int FRAMES_PER_STEP = 60,
    parameter int FRAME_CNT_BITS  = 16
) (
    input  logic                        I_clk_pixel,
    input  logic                        I_reset_n,
    input  logic [VIDEO_X_BITWIDTH-1:0] pixX,
    input  logic [VIDEO_Y_BITWIDTH-1:0] pixY,
    input  logic [VIDEO_X_BITWIDTH-1:0] screenWidth,
    input  logic [VIDEO_Y_BITWIDTH-1:0] screenHeight,
    input  logic                        I_req_valid,
    input  logic [2:0]                  I_req_pattern,
    input  logic [23:0]                 I_req_color,
    output logic                        O_req_ready,
    output logic [2:0]                  O_pattern,
    output logic [23:0]                 O_color,
    output logic [2:0]                  O_palette_idx,
    output logic                        O_frame_start,
    output logic [FRAME_CNT_BITS-1:0]   O_frame_cnt
);

    // Dwell counter must hold 0..FRAMES_PER_STEP-1 and never be zero-width.
    localparam int                 DWELL_W    = $clog2(FRAMES_PER_STEP + 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(FRAMES_PER_STEP - 1);

    logic frame_start;

    frame_tick_gen #(
        .FRAME_CNT_BITS(FRAME_CNT_BITS)
    ) u_frame_tick_gen (
        .I_clk_pixel  (I_clk_pixel),
        .I_reset_n    (I_reset_n),
        .pixX         (pixX),
        .pixY         (pixY),
        .screenWidth  (screenWidth),
        .screenHeight (screenHeight),
        .O_frame_start(frame_start),
        .O_frame_cnt  (O_frame_cnt)
    );

    state_t             state_d,      state_q;
    logic [DWELL_W-1:0] dwell_d,      dwell_q;
    logic [2:0]         idx_d,        idx_q;
    logic [2:0]         pattern_d,    pattern_q;
    logic [23:0]        color_d,      color_q;
    logic               ready_d,      ready_q;
    logic               pending_d,    pending_q;
    logic [2:0]         pend_pat_d,   pend_pat_q;
    logic [23:0]        pend_color_d, pend_color_q;
    logic               transfer;

    // Next-state: commit a pending request at the frame boundary (it wins
    // over an AUTO step in that frame), otherwise advance AUTO dwell/palette;
    // independently capture a new request when the port is ready.
    always_comb begin
        state_d      = state_q;
        dwell_d      = dwell_q;
        idx_d        = idx_q;
        pattern_d    = pattern_q;
        color_d      = color_q;
        ready_d      = ready_q;
        pending_d    = pending_q;
        pend_pat_d   = pend_pat_q;
        pend_color_d = pend_color_q;
        transfer     = I_req_valid && ready_q;

        if (frame_start && pending_q) begin
            pending_d = 1'b0;
            ready_d   = 1'b1;
            if (pend_pat_q == PAT_RAINBOW_AUTO) begin
                state_d   = ST_AUTO;
                dwell_d   = '0;
                pattern_d = PAT_RAINBOW_AUTO;
                color_d   = palette_color(idx_q);
            end else begin
                state_d   = ST_MANUAL;
                pattern_d = pend_pat_q;
                color_d   = pend_color_q;
            end
        end else if (frame_start && (state_q == ST_AUTO)) begin
            if (dwell_q == DWELL_LAST) begin
                dwell_d = '0;
                idx_d   = idx_q + 3'd1;
                color_d = palette_color(idx_q + 3'd1);
            end else begin
                dwell_d = dwell_q + DWELL_W'(1);
            end
        end

        // ready_q is low whenever pending_q is high, so a capture can never
        // collide with the commit above.
        if (transfer) begin
            pend_pat_d   = I_req_pattern;
            pend_color_d = I_req_color;
            pending_d    = 1'b1;
            ready_d      = 1'b0;
        end
    end

    // Controller state registers; reset discards any pending request.
    always_ff @(posedge I_clk_pixel) begin
        if (!I_reset_n) begin
            state_q      <= ST_AUTO;
            dwell_q      <= '0;
            idx_q        <= 3'd0;
            pattern_q    <= PAT_RAINBOW_AUTO;
            color_q      <= 24'hff0000;
            ready_q      <= 1'b1;
            pending_q    <= 1'b0;
            pend_pat_q   <= 3'd0;
            pend_color_q <= 24'h000000;
        end else begin
            state_q      <= state_d;
            dwell_q      <= dwell_d;
            idx_q        <= idx_d;
            pattern_q    <= pattern_d;
            color_q      <= color_d;
            ready_q      <= ready_d;
            pending_q    <= pending_d;
            pend_pat_q   <= pend_pat_d;
            pend_color_q <= pend_color_d;
        end
    end

    assign O_req_ready   = ready_q;
    assign O_pattern     = pattern_q;
    assign O_color       = color_q;
    assign O_palette_idx = idx_q;
    assign O_frame_start = frame_start;

endmodule

// File: tb/tb_video_pattern_sequencer.sv
// Bench for video_pattern_sequencer on an 8x4 screen with FRAMES_PER_STEP=2.
// A per-frame expectation table drives the sequence; frame pulses are checked
// through a scoreboard queue filled when the last pixel is driven.
module tb_video_pattern_sequencer;
    import video_pattern_sequencer_pkg::*;

    localparam int FPS = 2;
    localparam int FCB = 16;
    localparam int NFR = 29;
    localparam int ACT_NONE   = 0;
    localparam int ACT_MANUAL = 1;
    localparam int ACT_RETURN = 2;
    localparam int ACT_HELD   = 3;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic [VIDEO_X_BITWIDTH-1:0] px;
    logic [VIDEO_Y_BITWIDTH-1:0] py;
    logic [VIDEO_X_BITWIDTH-1:0] sw;
    logic [VIDEO_Y_BITWIDTH-1:0] sh;
    logic                        req_valid;
    logic [2:0]                  req_pattern;
    logic [23:0]                 req_color;
    logic                        req_ready;
    logic [2:0]                  pattern;
    logic [23:0]                 color;
    logic [2:0]                  pal_idx;
    logic                        frame_start;
    logic [FCB-1:0]              frame_cnt;

    video_pattern_sequencer #(
        .FRAMES_PER_STEP(FPS),
        .FRAME_CNT_BITS (FCB)
    ) dut (
        .I_clk_pixel  (clk),
        .I_reset_n    (rst_n),
        .pixX         (px),
        .pixY         (py),
        .screenWidth  (sw),
        .screenHeight (sh),
        .I_req_valid  (req_valid),
        .I_req_pattern(req_pattern),
        .I_req_color  (req_color),
        .O_req_ready  (req_ready),
        .O_pattern    (pattern),
        .O_color      (color),
        .O_palette_idx(pal_idx),
        .O_frame_start(frame_start),
        .O_frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          action;
        logic [2:0]  pat;
        logic [23:0] color;
        logic [2:0]  idx;
        logic        ready;
    } vec_t;

    vec_t        tbl [1:NFR];
    int unsigned sb_q [$];
    int unsigned exp_cnt;
    int          checks;
    int          errors;
    int          pulses;
    logic        scan_en;
    logic        prev_eof;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: observe outputs after the edge, score any frame pulse, then
    // drive the next pixel and queue an expectation on a new last-pixel hit.
    task automatic cyc();
        logic cur_eof;
        @(posedge clk);
        #1;
        if (frame_start) begin
            pulses++;
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_pulse", 32'd1, 32'd0);
            end else begin
                chk("sb_frame_cnt", 32'(frame_cnt), sb_q.pop_front());
            end
        end
        if (scan_en) begin
            if (px == sw - 1) begin
                px = '0;
                py = (py == sh - 1) ? '0 : py + 1'b1;
            end else begin
                px = px + 1'b1;
            end
        end
        cur_eof = (px == 7) && (py == 3);
        if (rst_n && cur_eof && !prev_eof) begin
            exp_cnt++;
            sb_q.push_back(exp_cnt & 32'hffff);
        end
        prev_eof = rst_n ? cur_eof : 1'b0;
    endtask

    task automatic goto_pix(input int x, input int y);
        int n = 0;
        while (!((px == x) && (py == y)) && n < 64) begin
            cyc();
            n++;
        end
        if (n >= 64) chk("goto_timeout", 32'd1, 32'd0);
    endtask

    // Wait for the next frame pulse, then one more cycle so the commit shows.
    task automatic wait_frame();
        logic got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (frame_start) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("frame_timeout", 32'd0, 32'd1);
        cyc();
    endtask

    task automatic send_req(input logic [2:0] p, input logic [23:0] c);
        req_valid   = 1'b1;
        req_pattern = p;
        req_color   = c;
        cyc();
        req_valid   = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        sb_q.delete();
        exp_cnt  = 0;
        prev_eof = 1'b0;
        repeat (n) cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        int p0;
        checks = 0; errors = 0; pulses = 0; exp_cnt = 0;
        scan_en = 1'b1; prev_eof = 1'b0;
        px = '0; py = '0; sw = 8; sh = 4;
        req_valid = 1'b0; req_pattern = 3'd0; req_color = 24'h0;
        rst_n = 1'b0;

        tbl[1]  = '{ACT_NONE,   3'd0, 24'hff0000, 3'd0, 1'b1};
        tbl[2]  = '{ACT_NONE,   3'd0, 24'h00ff00, 3'd1, 1'b1};
        tbl[3]  = '{ACT_NONE,   3'd0, 24'h00ff00, 3'd1, 1'b1};
        tbl[4]  = '{ACT_NONE,   3'd0, 24'hffff00, 3'd2, 1'b1};
        tbl[5]  = '{ACT_NONE,   3'd0, 24'hffff00, 3'd2, 1'b1};
        tbl[6]  = '{ACT_NONE,   3'd0, 24'h0000ff, 3'd3, 1'b1};
        tbl[7]  = '{ACT_NONE,   3'd0, 24'h0000ff, 3'd3, 1'b1};
        tbl[8]  = '{ACT_NONE,   3'd0, 24'hff00ff, 3'd4, 1'b1};
        tbl[9]  = '{ACT_NONE,   3'd0, 24'hff00ff, 3'd4, 1'b1};
        tbl[10] = '{ACT_NONE,   3'd0, 24'h00ffff, 3'd5, 1'b1};
        tbl[11] = '{ACT_NONE,   3'd0, 24'h00ffff, 3'd5, 1'b1};
        tbl[12] = '{ACT_NONE,   3'd0, 24'hffffff, 3'd6, 1'b1};
        tbl[13] = '{ACT_NONE,   3'd0, 24'hffffff, 3'd6, 1'b1};
        tbl[14] = '{ACT_NONE,   3'd0, 24'hff9900, 3'd7, 1'b1};
        tbl[15] = '{ACT_NONE,   3'd0, 24'hff9900, 3'd7, 1'b1};
        tbl[16] = '{ACT_NONE,   3'd0, 24'hff0000, 3'd0, 1'b1};
        tbl[17] = '{ACT_NONE,   3'd0, 24'hff0000, 3'd0, 1'b1};
        tbl[18] = '{ACT_NONE,   3'd0, 24'h00ff00, 3'd1, 1'b1};
        tbl[19] = '{ACT_NONE,   3'd0, 24'h00ff00, 3'd1, 1'b1};
        tbl[20] = '{ACT_NONE,   3'd0, 24'hffff00, 3'd2, 1'b1};
        tbl[21] = '{ACT_NONE,   3'd0, 24'hffff00, 3'd2, 1'b1};
        tbl[22] = '{ACT_NONE,   3'd0, 24'h0000ff, 3'd3, 1'b1};
        tbl[23] = '{ACT_MANUAL, 3'd1, 24'h123456, 3'd3, 1'b1};
        tbl[24] = '{ACT_NONE,   3'd1, 24'h123456, 3'd3, 1'b1};
        tbl[25] = '{ACT_RETURN, 3'd0, 24'h0000ff, 3'd3, 1'b1};
        tbl[26] = '{ACT_NONE,   3'd0, 24'h0000ff, 3'd3, 1'b1};
        tbl[27] = '{ACT_NONE,   3'd0, 24'hff00ff, 3'd4, 1'b1};
        tbl[28] = '{ACT_HELD,   3'd0, 24'hff00ff, 3'd4, 1'b1};
        tbl[29] = '{ACT_NONE,   3'd0, 24'h00ffff, 3'd5, 1'b1};

        // Power-on reset, then leave a request pending and reset mid-frame.
        do_reset(3);
        send_req(3'd1, 24'h0badf0);
        chk("pre_reset_ready", 32'(req_ready), 32'd0);
        goto_pix(3, 1);
        do_reset(3);
        cyc();
        chk("rst_pattern",     32'(pattern),     32'd0);
        chk("rst_color",       32'(color),       32'hff0000);
        chk("rst_idx",         32'(pal_idx),     32'd0);
        chk("rst_frame_cnt",   32'(frame_cnt),   32'd0);
        chk("rst_frame_start", 32'(frame_start), 32'd0);
        chk("rst_ready",       32'(req_ready),   32'd1);

        for (int k = 1; k <= NFR; k++) begin
            case (tbl[k].action)
                ACT_MANUAL: begin
                    goto_pix(3, 1);
                    send_req(PAT_SOLID, 24'h123456);
                    chk("man_ready_low",    32'(req_ready), 32'd0);
                    chk("man_pat_held",     32'(pattern),   32'd0);
                    chk("man_color_held",   32'(color),     32'h0000ff);
                    cyc();
                    send_req(PAT_BARS, 24'habcdef);
                    chk("drop_ready_low",   32'(req_ready), 32'd0);
                    chk("drop_color_held",  32'(color),     32'h0000ff);
                    wait_frame();
                end
                ACT_RETURN: begin
                    goto_pix(3, 1);
                    send_req(PAT_RAINBOW_AUTO, 24'h777777);
                    chk("ret_ready_low",    32'(req_ready), 32'd0);
                    chk("ret_color_held",   32'(color),     32'h123456);
                    wait_frame();
                end
                ACT_HELD: begin
                    goto_pix(7, 3);
                    scan_en = 1'b0;
                    p0 = pulses;
                    repeat (10) cyc();
                    chk("held_one_pulse",   32'(pulses - p0), 32'd1);
                    scan_en = 1'b1;
                end
                default: wait_frame();
            endcase
            chk($sformatf("f%0d_pattern", k),   32'(pattern),     32'(tbl[k].pat));
            chk($sformatf("f%0d_color", k),     32'(color),       32'(tbl[k].color));
            chk($sformatf("f%0d_idx", k),       32'(pal_idx),     32'(tbl[k].idx));
            chk($sformatf("f%0d_ready", k),     32'(req_ready),   32'(tbl[k].ready));
            chk($sformatf("f%0d_frame_cnt", k), 32'(frame_cnt),   k);
            chk($sformatf("f%0d_no_pulse", k),  32'(frame_start), 32'd0);
        end

        chk("sb_drained", sb_q.size(), 32'd0);
        chk("pulse_total", pulses, NFR);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
